// File: rtl/uart_ctrl_param.sv
// rtl/uart_ctrl_param.sv - parametrised full-duplex UART with show-ahead RX FIFO and error flags.
// Optional even parity in both directions is enabled by defining UART_CTRL_PARITY_EN.
module uart_ctrl_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cmd_in,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    output logic              tx,
    input  logic              rx,
    output logic              read_rdy,
    output logic [DATA_W-1:0] read_data,
    input  logic              read_ack,
    output logic              rx_frm_err,
    output logic              rx_par_err,
    output logic              rx_ovf
);
`ifdef UART_CTRL_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = 4;
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL      = (AW+1)'(RX_DEPTH);
    localparam logic [AW:0]   ONE       = (AW+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t            tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic              tx_par_q, tx_par_d, rx_par_q, rx_par_d, rx_bad_q, rx_bad_d;
    logic              tx_q, tx_d, cmd_rdy_q, cmd_rdy_d;
    logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic              frm_err_q, frm_err_d, par_err_q, par_err_d, push_q, push_d;
    logic [DATA_W-1:0] push_data_q, push_data_d, read_data_q, read_data_d;
    logic [DATA_W-1:0] mem_q [RX_DEPTH];
    logic [DATA_W-1:0] mem_d [RX_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [AW:0]       count_q, count_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic              tx_tick, rx_tick, do_push, do_pop;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_tick    = (tx_cnt_q == CNT_LAST);
        if (tx_state_q != S_IDLE) begin
            if (tx_tick) tx_cnt_d = '0;
            else         tx_cnt_d = tx_cnt_q + 1'b1;
        end
        case (tx_state_q)
            S_IDLE: if (cmd_vld && cmd_rdy_q) begin
                tx_state_d = S_START;
                tx_sh_d    = cmd_in;
                tx_par_d   = ^cmd_in;
                tx_cnt_d   = '0;
            end
            S_START: if (tx_tick) begin
                tx_state_d = S_DATA;
                tx_bit_d   = '0;
            end
            S_DATA: if (tx_tick) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 1'b1;
                if (tx_bit_q == DATA_LAST) begin
                    tx_bit_d   = '0;
                    tx_state_d = PAR_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (tx_tick) begin
                tx_state_d = S_STOP;
                tx_bit_d   = '0;
            end
            S_STOP: if (tx_tick) begin
                tx_bit_d = tx_bit_q + 1'b1;
                if (tx_bit_q == STOP_LAST) tx_state_d = S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
        // tx and cmd_rdy are registered from the next state so both change on the accept edge
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_sh_d[0];
            S_PARITY: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
        cmd_rdy_d = (tx_state_d == S_IDLE);
    end

    always_comb begin
        rx_s1_d     = rx;
        rx_s2_d     = rx_s1_q;
        rx_prev_d   = rx_s2_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 1'b1;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_par_d    = rx_par_q;
        rx_bad_d    = rx_bad_q;
        frm_err_d   = 1'b0;
        par_err_d   = 1'b0;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        rx_tick     = (rx_cnt_q == CNT_LAST);
        case (rx_state_q)
            // a falling edge needs a high sample first, so a line stuck low after a framing error is ignored
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == CNT_MID) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_par_d   = 1'b0;
                rx_bad_d   = 1'b0;
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_tick) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
                rx_par_d = rx_par_q ^ rx_s2_q;
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == DATA_LAST) rx_state_d = PAR_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: if (rx_tick) begin
                rx_cnt_d   = '0;
                rx_state_d = S_STOP;
                if (rx_s2_q != rx_par_q) begin
                    par_err_d = 1'b1;
                    rx_bad_d  = 1'b1;
                end
            end
            S_STOP: if (rx_tick) begin
                rx_state_d = S_IDLE;
                if (!rx_s2_q) frm_err_d = 1'b1;
                else if (!rx_bad_q) begin
                    push_d      = 1'b1;
                    push_data_d = rx_sh_q;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        do_pop      = read_ack && (count_q != '0);
        do_push     = push_q && ((count_q != FULL) || do_pop);
        rd_next     = rd_ptr_q + 1'b1;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        read_data_d = read_data_q;
        rx_ovf_d    = rx_ovf_q | (push_q & ~do_push);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        // read_data is a registered copy of the head, so it follows the head across push/pop
        if (do_pop) begin
            rd_ptr_d = rd_next;
            if (count_q == ONE) read_data_d = do_push ? push_data_q : read_data_q;
            else                read_data_d = mem_q[rd_next];
        end else if (count_q == '0 && do_push) begin
            read_data_d = push_data_q;
        end
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            tx_par_q    <= 1'b0;
            tx_q        <= 1'b1;
            cmd_rdy_q   <= 1'b0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            rx_par_q    <= 1'b0;
            rx_bad_q    <= 1'b0;
            frm_err_q   <= 1'b0;
            par_err_q   <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            read_data_q <= '0;
            rx_ovf_q    <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            tx_par_q    <= tx_par_d;
            tx_q        <= tx_d;
            cmd_rdy_q   <= cmd_rdy_d;
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_prev_q   <= rx_prev_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            rx_par_q    <= rx_par_d;
            rx_bad_q    <= rx_bad_d;
            frm_err_q   <= frm_err_d;
            par_err_q   <= par_err_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            read_data_q <= read_data_d;
            rx_ovf_q    <= rx_ovf_d;
        end
    end

    assign cmd_rdy    = cmd_rdy_q;
    assign tx         = tx_q;
    assign read_rdy   = (count_q != '0);
    assign read_data  = read_data_q;
    assign rx_frm_err = frm_err_q;
    assign rx_par_err = PAR_EN & par_err_q;
    assign rx_ovf     = rx_ovf_q;
endmodule

// File: tb/tb_uart_ctrl_param.sv
// tb/tb_uart_ctrl_param.sv - directed and randomized bench for uart_ctrl_param against a frame-level model.
module tb_uart_ctrl_param;
    localparam int DATA_W    = 8;
    localparam int CLK_DIV   = 16;
    localparam int STOP_BITS = 1;
    localparam int RX_DEPTH  = 4;
`ifdef UART_CTRL_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + DATA_W + P + STOP_BITS;
    localparam int NSAMP = NBITS * CLK_DIV + 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] cmd_in = '0;
    logic              cmd_vld = 1'b0;
    logic              cmd_rdy, tx, rx, read_rdy, rx_frm_err, rx_par_err, rx_ovf;
    logic [DATA_W-1:0] read_data;
    logic              read_ack = 1'b0;
    logic              rx_drv = 1'b1;
    logic              loopback = 1'b0;

    int checks = 0;
    int errors = 0;
    int frm_cnt = 0;
    int par_cnt = 0;
    logic [DATA_W-1:0] model_q [$];
    logic              ovf_exp = 1'b0;

    assign rx = loopback ? tx : rx_drv;

    uart_ctrl_param #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .STOP_BITS(STOP_BITS), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .tx(tx), .rx(rx),
        .read_rdy(read_rdy), .read_data(read_data), .read_ack(read_ack),
        .rx_frm_err(rx_frm_err), .rx_par_err(rx_par_err), .rx_ovf(rx_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_frm_err === 1'b1) frm_cnt++;
        if (rx_par_err === 1'b1) par_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of bit slot k of a frame carrying w; slots past the frame are idle-high.
    function automatic logic exp_tx_bit(input logic [DATA_W-1:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= DATA_W) return w[k-1];
        if (P == 1 && k == DATA_W + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic tx_frame(input logic [DATA_W-1:0] w, input string tag);
        logic tx_s [NSAMP];
        int rdy_at;
        int bad;
        check({tag, " rdy_before"}, cmd_rdy, 1);
        cmd_in  = w;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        rdy_at  = -1;
        for (int i = 0; i < NSAMP; i++) begin
            if (i == 20) begin
                cmd_in  = ~w;
                cmd_vld = 1'b1;
            end
            if (i == 21) cmd_vld = 1'b0;
            tx_s[i] = tx;
            if (rdy_at < 0 && cmd_rdy === 1'b1) rdy_at = i;
            @(negedge clk);
        end
        for (int k = 0; k < NBITS; k++)
            check($sformatf("%s bit%0d", tag, k), tx_s[k*CLK_DIV + CLK_DIV/2], exp_tx_bit(w, k));
        bad = 0;
        for (int i = 0; i < NSAMP; i++)
            if (tx_s[i] !== exp_tx_bit(w, i / CLK_DIV)) bad++;
        check({tag, " bit_hold_mismatches"}, bad, 0);
        check({tag, " busy_cycles"}, rdy_at, NBITS * CLK_DIV);
    endtask

    task automatic rx_frame(input logic [DATA_W-1:0] w, input logic stop_v, input logic par_flip);
        rx_drv = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < DATA_W; i++) begin
            rx_drv = w[i];
            repeat (CLK_DIV) @(negedge clk);
        end
`ifdef UART_CTRL_PARITY_EN
        rx_drv = (^w) ^ par_flip;
        repeat (CLK_DIV) @(negedge clk);
`endif
        rx_drv = stop_v;
        repeat (CLK_DIV) @(negedge clk);
        rx_drv = 1'b1;
        repeat ((STOP_BITS - 1) * CLK_DIV) @(negedge clk);
        if (stop_v && !(P == 1 && par_flip)) begin
            if (model_q.size() < RX_DEPTH) model_q.push_back(w);
            else ovf_exp = 1'b1;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [DATA_W-1:0] e;
        e = model_q.pop_front();
        check({tag, " read_rdy"}, read_rdy, 1);
        check({tag, " read_data"}, read_data, e);
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
    endtask

    initial begin
        int f0, p0, n;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst tx", tx, 1);
        check("rst cmd_rdy", cmd_rdy, 0);
        check("rst read_rdy", read_rdy, 0);
        check("rst read_data", read_data, 0);
        check("rst rx_ovf", rx_ovf, 0);
        check("rst rx_frm_err", rx_frm_err, 0);
        check("rst rx_par_err", rx_par_err, 0);
        rst = 1'b0;
        check("release cmd_rdy before edge", cmd_rdy, 0);
        @(negedge clk);
        check("release cmd_rdy after edge", cmd_rdy, 1);

        tx_frame(8'hA5, "tx_a5");
        for (int r = 0; r < 2; r++) tx_frame(DATA_W'($urandom), $sformatf("tx_rand%0d", r));

        cmd_in  = 8'h00;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        repeat (50) @(negedge clk);
        check("midreset tx before", tx, 0);
        #2 rst = 1'b1;
        #1;
        check("midreset tx async", tx, 1);
        check("midreset cmd_rdy", cmd_rdy, 0);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        ovf_exp = 1'b0;
        @(negedge clk);
        check("midreset cmd_rdy after", cmd_rdy, 1);
        repeat (3 * CLK_DIV) @(negedge clk);
        check("midreset tx idle", tx, 1);

        rx_frame(8'h3C, 1'b1, 1'b0);
        pop_check("rx_3c");
        check("rx_3c empty after ack", read_rdy, 0);

        f0 = frm_cnt;
        p0 = par_cnt;
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch no push", read_rdy, 0);
        check("glitch no frm_err", frm_cnt, f0);
        check("glitch no par_err", par_cnt, p0);

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) rx_frame(DATA_W'($urandom), 1'b1, 1'b0);
            while (model_q.size() > 0) pop_check($sformatf("rx_rand%0d", r));
            check($sformatf("rx_rand%0d empty", r), read_rdy, 0);
        end
        check("no overflow yet", rx_ovf, ovf_exp);

        for (int v = 1; v <= 5; v++) rx_frame(DATA_W'(v), 1'b1, 1'b0);
        check("ovf flag set", rx_ovf, ovf_exp);
        for (int j = 0; j < RX_DEPTH; j++) pop_check($sformatf("ovf_pop%0d", j));
        check("ovf drained", read_rdy, 0);
        check("ovf sticky", rx_ovf, ovf_exp);

        f0 = frm_cnt;
        rx_frame(8'h55, 1'b0, 1'b0);
        check("frm_err one pulse", frm_cnt, f0 + 1);
        check("frm_err no push", read_rdy, 0);
        repeat (10) @(negedge clk);
        rx_frame(8'h66, 1'b1, 1'b0);
        pop_check("after_frm 66");
        check("after_frm empty", read_rdy, 0);

`ifdef UART_CTRL_PARITY_EN
        f0 = frm_cnt;
        p0 = par_cnt;
        rx_frame(8'h5A, 1'b1, 1'b1);
        check("par_err one pulse", par_cnt, p0 + 1);
        check("par_err no frm_err", frm_cnt, f0);
        check("par_err no push", read_rdy, 0);
`endif

        p0 = par_cnt;
        loopback = 1'b1;
        tx_frame(8'h81, "loop_tx");
        loopback = 1'b0;
        model_q.push_back(8'h81);
        pop_check("loop_rx 81");
        check("loop no par_err", par_cnt, p0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
